// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, instruction
// classes, MIPS opcode/func constants and ALU operation codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_J, C_JAL, C_BR, C_ALUI, C_LOAD, C_STORE, C_ILLEGAL
   } cls_t;

   localparam logic [5:0] OP_RTYPE  = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                          OP_JAL    = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                          OP_BLEZ   = 6'h06, OP_BGTZ   = 6'h07, OP_ADDIU = 6'h09,
                          OP_SLTI   = 6'h0A, OP_SLTIU  = 6'h0B, OP_ANDI  = 6'h0C,
                          OP_ORI    = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F,
                          OP_LB     = 6'h20, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                          OP_SB     = 6'h28, OP_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                          FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                          FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20,
                          FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                          FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                          FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

   localparam logic [4:0] AOP_ADD  = 5'd0,  AOP_SUB  = 5'd1,  AOP_SLT  = 5'd2,
                          AOP_AND  = 5'd3,  AOP_NOR  = 5'd4,  AOP_OR   = 5'd5,
                          AOP_XOR  = 5'd6,  AOP_SLL  = 5'd7,  AOP_SRL  = 5'd8,
                          AOP_SLTU = 5'd9,  AOP_LINK = 5'd10, AOP_JR   = 5'd11,
                          AOP_SLLV = 5'd12, AOP_SRA  = 5'd13, AOP_SRAV = 5'd14,
                          AOP_SRLV = 5'd15, AOP_LUI  = 5'd16;

endpackage

// File: rtl/ctrl_dec.sv
// Combinational instruction decoder: op/func to class, ALU code and
// immediate sign-extension select.
module ctrl_dec
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W = 5
) (
   input  logic [5:0]         op,
   input  logic [5:0]         func,
   output cls_t               cls,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               ext_op
);

   logic [4:0] aop;

   always_comb begin
      cls    = C_ILLEGAL;
      aop    = AOP_ADD;
      ext_op = 1'b0;
      case (op)
         OP_RTYPE: begin
            cls = C_R;
            case (func)
               FN_SLL:          aop = AOP_SLL;
               FN_SRL:          aop = AOP_SRL;
               FN_SRA:          aop = AOP_SRA;
               FN_SLLV:         aop = AOP_SLLV;
               FN_SRLV:         aop = AOP_SRLV;
               FN_SRAV:         aop = AOP_SRAV;
               FN_JR:           aop = AOP_JR;
               FN_JALR:         aop = AOP_LINK;
               FN_ADD, FN_ADDU: aop = AOP_ADD;
               FN_SUB, FN_SUBU: aop = AOP_SUB;
               FN_AND:          aop = AOP_AND;
               FN_OR:           aop = AOP_OR;
               FN_XOR:          aop = AOP_XOR;
               FN_NOR:          aop = AOP_NOR;
               FN_SLT:          aop = AOP_SLT;
               FN_SLTU:         aop = AOP_SLTU;
               default:         cls = C_ILLEGAL;
            endcase
         end
         OP_J:                          cls = C_J;
         OP_JAL:                 begin cls = C_JAL; aop = AOP_LINK; end
         OP_REGIMM, OP_BLEZ, OP_BGTZ:   cls = C_BR;
         OP_BEQ, OP_BNE:         begin cls = C_BR;   aop = AOP_SUB;  end
         OP_ADDIU:               begin cls = C_ALUI; ext_op = 1'b1;  end
         OP_SLTI:                begin cls = C_ALUI; aop = AOP_SLT;  ext_op = 1'b1; end
         OP_SLTIU:               begin cls = C_ALUI; aop = AOP_SLTU; end
         OP_ANDI:                begin cls = C_ALUI; aop = AOP_AND;  end
         OP_ORI:                 begin cls = C_ALUI; aop = AOP_OR;   end
         OP_XORI:                begin cls = C_ALUI; aop = AOP_XOR;  end
         OP_LUI:                 begin cls = C_ALUI; aop = AOP_LUI;  end
         OP_LB, OP_LW, OP_LBU:   begin cls = C_LOAD;  ext_op = 1'b1; end
         OP_SB, OP_SW:           begin cls = C_STORE; ext_op = 1'b1; end
         default:                       cls = C_ILLEGAL;
      endcase
   end

   assign alu_op = ALUOP_W'(aop);

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle CPU control FSM with retired-instruction counter.
//   state  | meaning
//   FETCH  | read instruction, load IR and PC when memory is ready
//   DECODE | latch op/func, resolve J / JAL / illegal
//   EXEC   | drive ALU controls, resolve branches
//   MEM    | load or store data access, wait for memory
//   WB     | register file write-back
module multi_ctrl
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W     = 5,
   parameter int MEM_WAIT_EN = 1,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        ins,
   input  logic               mem_ready,
   output logic               pc_wr,
   output logic               ir_wr,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               reg_wr,
   output logic               reg_dst,
   output logic               alu_src,
   output logic               ext_op,
   output logic               mem_to_reg,
   output logic               branch,
   output logic               jump,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [2:0]         state,
   output logic               illegal,
   output logic [CNT_W-1:0]   retired
);

   state_t             st;
   logic               rst_q;
   logic [5:0]         op_q, func_q;
   logic [5:0]         dec_op, dec_func;
   cls_t               cls;
   logic [ALUOP_W-1:0] aop;
   logic               ext;
   logic               rdy;
   logic               unused_ins;

   assign unused_ins = ^ins[25:6];
   assign rdy        = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   // DECODE looks at the live word; later states use the latched fields.
   assign dec_op   = (st == S_DECODE) ? ins[31:26] : op_q;
   assign dec_func = (st == S_DECODE) ? ins[5:0]   : func_q;

   ctrl_dec #(.ALUOP_W(ALUOP_W)) u_dec (
      .op     (dec_op),
      .func   (dec_func),
      .cls    (cls),
      .alu_op (aop),
      .ext_op (ext)
   );

   // rst_q keeps the first post-reset cycle quiet so FETCH starts after release.
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= S_FETCH;
         rst_q   <= 1'b1;
         op_q    <= '0;
         func_q  <= '0;
         retired <= '0;
      end else begin
         rst_q <= 1'b0;
         if (rst_q) begin
            st <= S_FETCH;
         end else begin
            case (st)
               S_FETCH: if (rdy) st <= S_DECODE;
               S_DECODE: begin
                  op_q   <= ins[31:26];
                  func_q <= ins[5:0];
                  case (cls)
                     C_J: begin
                        st      <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                     end
                     C_ILLEGAL: st <= S_FETCH;
                     C_JAL:     st <= S_WB;
                     default:   st <= S_EXEC;
                  endcase
               end
               S_EXEC: begin
                  case (cls)
                     C_BR: begin
                        st      <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                     end
                     C_LOAD, C_STORE: st <= S_MEM;
                     default:         st <= S_WB;
                  endcase
               end
               S_MEM: begin
                  if (rdy) begin
                     if (cls == C_STORE) begin
                        st      <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                     end else begin
                        st <= S_WB;
                     end
                  end
               end
               S_WB: begin
                  st      <= S_FETCH;
                  retired <= retired + CNT_W'(1);
               end
               default: st <= S_FETCH;
            endcase
         end
      end
   end

   always_comb begin
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      ext_op     = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      illegal    = 1'b0;
      alu_op     = '0;
      if (!rst_q) begin
         case (st)
            S_FETCH: begin
               mem_rd = 1'b1;
               ir_wr  = rdy;
               pc_wr  = rdy;
            end
            S_DECODE: begin
               jump    = (cls == C_J);
               pc_wr   = (cls == C_J);
               illegal = (cls == C_ILLEGAL);
            end
            S_EXEC: begin
               alu_src = (cls == C_ALUI) || (cls == C_LOAD) || (cls == C_STORE);
               ext_op  = ext;
               alu_op  = aop;
               branch  = (cls == C_BR);
            end
            S_MEM: begin
               alu_src = 1'b1;
               ext_op  = ext;
               alu_op  = aop;
               mem_rd  = (cls == C_LOAD);
               mem_wr  = (cls == C_STORE);
            end
            S_WB: begin
               reg_wr     = 1'b1;
               reg_dst    = (cls == C_R);
               mem_to_reg = (cls == C_LOAD);
               alu_op     = aop;
            end
            default: ;
         endcase
      end
   end

   assign state = st;

endmodule

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 The module SHALL have parameter ALUOP_W, default 5, meaning the ALU operation code width (minimum 5).
REQ-002 The module SHALL have parameter MEM_WAIT_EN, default 1, meaning: 1 honours mem_ready; 0 treats memory as always ready.
REQ-003 The module SHALL have parameter CNT_W, default 32, meaning the retired-instruction counter width.
REQ-004 The module SHALL have port clk  in  1  rising-edge clock.
REQ-005 The module SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 The module SHALL have port ins  in  32  instruction word from the instruction register or memory.
REQ-007 The module SHALL have port mem_ready  in  1  memory access complete this cycle.
REQ-008 The module SHALL have outputs pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, alu_src, ext_op, mem_to_reg, branch, jump, each  out  1  datapath strobes and selects.
REQ-009 The module SHALL have port alu_op  out  ALUOP_W  ALU operation code.
REQ-010 The module SHALL have port state  out  3  current FSM state, for debug.
REQ-011 The module SHALL have port illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-012 The module SHALL have port retired  out  CNT_W  count of completed instructions.

Function
REQ-013 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next cycle.
REQ-014 In FETCH the FSM SHALL assert mem_rd; on the cycle mem_ready=1 it SHALL assert ir_wr and pc_wr for one cycle and go to DECODE; otherwise it SHALL hold.
REQ-015 In DECODE the FSM SHALL register decode fields from ins (op=ins[31:26], func=ins[5:0]); those fields SHALL stay stable until the next DECODE.
REQ-016 DECODE transitions: J: jump=1, pc_wr=1, then FETCH; JAL: then WB; illegal opcode or unlisted R-func: illegal=1 for one cycle, then FETCH; all others: then EXEC.
REQ-017 In EXEC the FSM SHALL drive alu_src, ext_op and alu_op from the registered decode.
REQ-018 EXEC transitions: BLTZ/BGEZ(op 01), BEQ, BNE, BLEZ, BGTZ: branch=1 for one cycle, then FETCH; loads/stores: then MEM; ALU ops: then WB.
REQ-019 In MEM, loads (LB, LW, LBU) SHALL assert mem_rd and stores (SW, SB) SHALL assert mem_wr, held until mem_ready=1.
REQ-020 MEM transitions: loads then WB; stores then FETCH.
REQ-021 In WB the FSM SHALL assert reg_wr for exactly one cycle with reg_dst=1 for R-type, mem_to_reg=1 for loads, alu_op=01010 for JAL, then go to FETCH.
REQ-022 retired SHALL increment by 1 on each completing transition (J, branch, store, and WB exits to FETCH), wrap modulo 2^CNT_W, and not count illegal.
REQ-023 All strobes (pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, branch, jump, illegal) SHALL be 0 outside the states named above.
REQ-024 alu_op codes: ADD/ADDU/ADDIU/loads/stores/BLTZ/BLEZ/BGTZ 0; SUB/SUBU/BEQ/BNE 1; SLT/SLTI 2; AND/ANDI 3; NOR 4; OR/ORI 5; XOR/XORI 6; SLL 7; SRL 8; SLTU/SLTIU 9; JALR/JAL 10; JR 11; SLLV 12; SRA 13; SRAV 14; SRLV 15; LUI 16; zero-extended to ALUOP_W.
REQ-025 ext_op SHALL be 1 for ADDIU, SLTI, loads and stores, and 0 otherwise.
REQ-026 branch SHALL never be asserted for SB.
REQ-027 With MEM_WAIT_EN=0, FETCH and MEM SHALL each last exactly one cycle.

Reset
REQ-028 When rst=1 at a clock edge, state SHALL become FETCH, retired 0, registered decode 0, and all strobes 0 on the next cycle, including when rst is asserted mid-MEM or mid-wait.
REQ-029 The first FETCH SHALL begin on the cycle after rst deasserts.

Structure
REQ-030 A shared package ctrl_pkg SHALL hold the opcode and func constants, the alu_op codes, and the state encoding.
REQ-031 A combinational sub-module ctrl_dec SHALL map op/func to class (R, J, JAL, BR, ALUI, LOAD, STORE, ILLEGAL), alu_op and ext_op; multi_ctrl SHALL own the FSM and counter.

Verification
REQ-032 ADDIU 0x24080005 with mem_ready=1 -> states 0,1,2,4,0; ext_op=1 and alu_op=0 in EXEC; one reg_wr; retired=1.
REQ-033 LW 0x8C090004 with mem_ready low for 3 cycles in MEM -> mem_rd held 4 cycles; mem_to_reg=1 and reg_wr in WB; total 8 cycles.
REQ-034 BEQ 0x10000003 -> branch pulses once in EXEC and alu_op=1; no reg_wr or mem_wr; back to FETCH.
REQ-035 Opcode 0x3F -> illegal pulses once in DECODE, then FETCH; retired unchanged.
REQ-036 rst=1 asserted while in MEM during SW -> mem_wr=0 and state=FETCH the next cycle, retired=0.
REQ-037 CNT_W=4 with 16 ADDIU -> retired wraps to 0.
